multiplier_t_c3x2_pipelined_mac: RTL and testbench
==================================================

MULTIPLIER_T_C3X2_PIPELINED_MAC -- requirements
Module: multiplier_t_c3x2_pipelined_mac

Interface
REQ-001 SHALL have parameter SUB_W, default 9, meaning width of one SIMD sub-operand.
REQ-002 SHALL have parameter N_SUB, default 3, meaning sub-products summed per channel; A_W = N_SUB*SUB_W (27).
REQ-003 SHALL have parameter B_W, default 18, meaning B width in full mode.
REQ-004 SHALL have parameter ACC_W, default 48, meaning result/accumulator width; it SHALL be at least A_W+B_W.
REQ-005 SHALL have parameter LAT, default 3, meaning accept-to-output latency in cycles; it SHALL be at least 2.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  clock, rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  input beat present.
REQ-010 in_ready  out  1  block accepts beat this cycle.
REQ-011 a  in  2*A_W  operand A; two channels of N_SUB lanes in mode 1.
REQ-012 b  in  2*A_W  operand B; same lane packing as a.
REQ-013 a_sign, b_sign  in  1 each  1 = operand signed (two's complement).
REQ-014 mode  in  1  0 = full A_W x B_W; 1 = per-channel sum of N_SUB SUB_W x SUB_W products.
REQ-015 acc_en  in  1  add this beat to the previous output instead of replacing it.
REQ-016 ovf_clr  in  1  clear sticky overflow flags.
REQ-017 out_valid  out  1  result present.
REQ-018 out_ready  in  1  downstream takes result.
REQ-019 result_0, result_1  out  ACC_W each  channel 0 and channel 1 result.
REQ-020 ovf  out  2  sticky overflow flags, bit i for channel i.

Function
REQ-021 Beat accepted SHALL mean in_valid & in_ready on a rising clk edge; a, b, signs, mode and acc_en SHALL be captured with it.
REQ-022 Pipeline advance SHALL be en = !out_valid | out_ready; in_ready = en; all stages SHALL hold when en = 0.
REQ-023 Bubbles SHALL occupy stages; an accepted beat SHALL appear at the output exactly LAT advancing cycles after acceptance.
REQ-024 Beats SHALL leave in acceptance order, with none lost or duplicated under any out_ready pattern.
REQ-025 Mode 0: product P = a[A_W-1:0] x b[B_W-1:0].
  - Each operand sign- or zero-extended per its sign flag.
  - P SHALL be extended to ACC_W on channel 0.
  - Channel 1 product SHALL be 0; a/b bits above the used fields SHALL be ignored.
REQ-026 Mode 1: channel c product P_c = sum over k < N_SUB of lane(a,c,k) x lane(b,c,k).
  - lane(x,c,k) = x[(c*N_SUB+k)*SUB_W +: SUB_W], extended per its sign flag.
  - Sum computed exactly in 2*SUB_W+2 bits, then extended to ACC_W.
REQ-027 Output stage, per channel:
  - acc_en = 1 and the previous delivered beat had the same mode: result_c <= result_c + P_c, modulo 2^ACC_W.
  - Otherwise: result_c <= P_c.
  - A mode change SHALL restart accumulation.
REQ-028 The previous delivered beat SHALL be the last beat that left the output. After reset none exists, and acc_en SHALL be treated as 0.
REQ-029 Overflow, evaluated only on accumulating beats:
  - ovf[c] SHALL set on signed overflow when a_sign | b_sign, else on unsigned carry-out of the ACC_W add.
REQ-030 ovf SHALL remain set until ovf_clr; if ovf_clr coincides with a new overflow, set SHALL win.
REQ-031 result_0, result_1 and out_valid SHALL be registered and SHALL stay stable while out_valid & !out_ready.
REQ-032 in_valid = 0 with en = 1 SHALL inject a bubble; out_valid SHALL fall after the last beat is taken.

Reset
REQ-033 With reset_n low, SHALL hold: out_valid = 0, result_0 = result_1 = 0, ovf = 0, all stage-valid bits 0, in_ready = 1.
REQ-034 Reset asserted mid-operation SHALL discard every in-flight beat and the accumulator; the first beat after release SHALL be treated as non-accumulating.

Verification
REQ-035 Reset: 2 beats in flight, reset_n low for 1 cycle -> out_valid = 0, results 0, ovf = 0; neither beat emerges.
REQ-036 Mode 0, signed/signed, a = 27'h7FFFFFF, b = 18'h00002, out_ready = 1:
  - 3 cycles later result_0 = 48'hFFFFFFFFFFFE and result_1 = 0.
REQ-037 Mode 1, unsigned, all lanes a = b = 511 -> result_0 = result_1 = 783363 (20'hBF403).
REQ-038 Mode 0 unsigned, a = b = 1000, four beats with acc_en = 0,1,1,1:
  - Outputs 1000000, 2000000, 3000000, 4000000.
  - A fifth beat in mode 1 with acc_en = 1 restarts the accumulation.
REQ-039 Backpressure: 3 beats accepted, out_ready = 0 for 5 cycles:
  - in_ready = 0 and result held.
  - After release, all 3 results emerge in order on consecutive cycles.
REQ-040 Overflow: unsigned, a = 2^27-1, b = 2^18-1, acc_en = 1 after the first beat:
  - ovf[0] = 0 through beat 8, ovf[0] = 1 at beat 9.
  - ovf_clr pulse -> 0; ovf[1] stays 0.

Source files
------------

// File: rtl/multiplier_t_c3x2_pipelined_mac.sv
// rtl/multiplier_t_c3x2_pipelined_mac.sv - two-channel SIMD multiply-accumulate pipeline
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; a beat is accepted on in_valid & in_ready
//   a, b                operands, 2*A_W bits; six SUB_W lanes in mode 1
//   a_sign, b_sign      operand signedness (1 = two's complement)
//   mode                0 = full A_W x B_W product on channel 0,
//                       1 = per-channel dot product of N_SUB lanes
//   acc_en              accumulate onto the previous delivered result
//   ovf_clr             clear sticky overflow flags
//   out_valid/out_ready output handshake
//   result_0, result_1  channel results, ACC_W bits each
//   ovf                 sticky overflow flags, bit i for channel i
module multiplier_t_c3x2_pipelined_mac #(
    parameter int SUB_W = 9,
    parameter int N_SUB = 3,
    parameter int B_W   = 18,
    parameter int ACC_W = 48,
    parameter int LAT   = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2*N_SUB*SUB_W-1:0]       a,
    input  logic [2*N_SUB*SUB_W-1:0]       b,
    input  logic                           a_sign,
    input  logic                           b_sign,
    input  logic                           mode,
    input  logic                           acc_en,
    input  logic                           ovf_clr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               result_0,
    output logic [ACC_W-1:0]               result_1,
    output logic [1:0]                     ovf
);

    localparam int A_W   = N_SUB * SUB_W;
    localparam int SUM_W = 2 * SUB_W + 2;
    // Product stages ahead of the output register; the output register is the last of LAT.
    localparam int NS    = LAT - 1;

    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // Dot product of one channel's lanes, summed exactly in SUM_W bits, then
    // sign- or zero-extended depending on whether either operand is signed.
    function automatic logic [ACC_W-1:0] chan_dot(
        input logic [2*A_W-1:0] x,
        input logic [2*A_W-1:0] y,
        input logic             xs,
        input logic             ys,
        input int               c
    );
        logic signed [SUM_W-1:0] s;
        logic [SUB_W-1:0]        xl;
        logic [SUB_W-1:0]        yl;
        logic signed [SUB_W:0]   xe;
        logic signed [SUB_W:0]   ye;
        s = '0;
        for (int k = 0; k < N_SUB; k++) begin
            xl = x[(c*N_SUB+k)*SUB_W +: SUB_W];
            yl = y[(c*N_SUB+k)*SUB_W +: SUB_W];
            xe = {xs & xl[SUB_W-1], xl};
            ye = {ys & yl[SUB_W-1], yl};
            s  = s + SUM_W'(xe) * SUM_W'(ye);
        end
        return (xs | ys) ? ACC_W'(s) : ACC_W'($unsigned(s));
    endfunction

    // Overflow of x + y: signed overflow or unsigned carry-out.
    function automatic logic add_ovf(
        input logic [ACC_W-1:0] x,
        input logic [ACC_W-1:0] y,
        input logic             sgn
    );
        logic [ACC_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (sgn)
            return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
        else
            return s[ACC_W];
    endfunction

    // Products formed from the raw inputs and captured at acceptance.
    logic signed [A_W:0] ax;
    logic signed [B_W:0] bx;
    logic [ACC_W-1:0]    p0_c;
    logic [ACC_W-1:0]    p1_c;

    always_comb begin
        ax   = {a_sign & a[A_W-1], a[A_W-1:0]};
        bx   = {b_sign & b[B_W-1], b[B_W-1:0]};
        p0_c = '0;
        p1_c = '0;
        if (!mode) begin
            p0_c = ACC_W'(ax) * ACC_W'(bx);
        end else begin
            p0_c = chan_dot(a, b, a_sign, b_sign, 0);
            p1_c = chan_dot(a, b, a_sign, b_sign, 1);
        end
    end

    // Product pipeline. Only the valid bits need reset; payload follows them.
    logic [NS-1:0]    st_v;
    logic [NS-1:0]    st_mode;
    logic [NS-1:0]    st_acc;
    logic [NS-1:0]    st_sgn;
    logic [ACC_W-1:0] st_p0 [NS];
    logic [ACC_W-1:0] st_p1 [NS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_v <= '0;
        end else if (en) begin
            st_v[0] <= in_valid;
            for (int i = 1; i < NS; i++) begin
                st_v[i] <= st_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            st_mode[0] <= mode;
            st_acc[0]  <= acc_en;
            st_sgn[0]  <= a_sign | b_sign;
            st_p0[0]   <= p0_c;
            st_p1[0]   <= p1_c;
            for (int i = 1; i < NS; i++) begin
                st_mode[i] <= st_mode[i-1];
                st_acc[i]  <= st_acc[i-1];
                st_sgn[i]  <= st_sgn[i-1];
                st_p0[i]   <= st_p0[i-1];
                st_p1[i]   <= st_p1[i-1];
            end
        end
    end

    // Output stage. Every beat loaded here is delivered before the next one
    // loads (loading requires out_ready while out_valid), so the beat in the
    // output register is always the previous delivered beat for the next load.
    logic       have_prev;
    logic       prev_mode;
    logic       load;
    logic       accum;
    logic [1:0] ov_hit;
    logic [ACC_W-1:0] nxt0;
    logic [ACC_W-1:0] nxt1;

    always_comb begin
        load      = en & st_v[NS-1];
        accum     = st_acc[NS-1] & have_prev & (prev_mode == st_mode[NS-1]);
        ov_hit[0] = add_ovf(result_0, st_p0[NS-1], st_sgn[NS-1]);
        ov_hit[1] = add_ovf(result_1, st_p1[NS-1], st_sgn[NS-1]);
        nxt0      = accum ? result_0 + st_p0[NS-1] : st_p0[NS-1];
        nxt1      = accum ? result_1 + st_p1[NS-1] : st_p1[NS-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result_0  <= '0;
            result_1  <= '0;
            ovf       <= '0;
            have_prev <= 1'b0;
            prev_mode <= 1'b0;
        end else begin
            if (en) begin
                out_valid <= st_v[NS-1];
            end
            if (load) begin
                result_0  <= nxt0;
                result_1  <= nxt1;
                have_prev <= 1'b1;
                prev_mode <= st_mode[NS-1];
            end
            // A new overflow wins over a simultaneous clear.
            ovf <= (ovf & ~{2{ovf_clr}}) | ({2{load & accum}} & ov_hit);
        end
    end

endmodule

// File: tb/tb_multiplier_t_c3x2_pipelined_mac.sv
// tb/tb_multiplier_t_c3x2_pipelined_mac.sv - scoreboard bench for the SIMD MAC pipeline
module tb_multiplier_t_c3x2_pipelined_mac;

    localparam int A_W   = 27;
    localparam int ACC_W = 48;
    localparam longint MASK = (longint'(1) << 48) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [2*A_W-1:0] a = '0;
    logic [2*A_W-1:0] b = '0;
    logic a_sign = 1'b0, b_sign = 1'b0, mode = 1'b0, acc_en = 1'b0, ovf_clr = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [ACC_W-1:0] result_0, result_1;
    logic [1:0] ovf;

    multiplier_t_c3x2_pipelined_mac dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign), .mode(mode), .acc_en(acc_en),
        .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
        .result_0(result_0), .result_1(result_1), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [47:0] r0; logic [47:0] r1; logic [1:0] ovf; } exp_t;
    typedef struct { logic [47:0] r0; logic [47:0] r1; logic [1:0] ovf; int cyc; } obs_t;
    exp_t sb_q[$];
    obs_t obs_q[$];

    int errors = 0;
    int checks = 0;
    bit rnd_bp = 1'b0;
    int issue_cyc;

    // Reference model state: last accepted beat stands in for the last delivered one.
    bit         m_have = 1'b0;
    bit         m_mode = 1'b0;
    longint     m_r[2] = '{0, 0};
    logic [1:0] m_ovf = 2'b00;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endfunction

    function automatic longint sx(longint v, int w);
        return v[w-1] ? v - (longint'(1) << w) : v;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_have = 0; m_mode = 0; m_r[0] = 0; m_r[1] = 0; m_ovf = 2'b00;
    endtask

    task automatic model_push(logic [53:0] av, logic [53:0] bv, bit as, bit bs, bit md, bit ac);
        longint p[2];
        longint x, y, s;
        bit accum, ov;
        p[0] = 0; p[1] = 0;
        if (!md) begin
            x = longint'(av[26:0]);
            y = longint'(bv[17:0]);
            if (as) x = sx(x, 27);
            if (bs) y = sx(y, 18);
            p[0] = x * y;
        end else begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 3; k++) begin
                    x = longint'((av >> ((c*3+k)*9)) & 54'd511);
                    y = longint'((bv >> ((c*3+k)*9)) & 54'd511);
                    if (as) x = sx(x, 9);
                    if (bs) y = sx(y, 9);
                    p[c] += x * y;
                end
        end
        accum = ac && m_have && (m_mode == md);
        for (int c = 0; c < 2; c++) begin
            if (accum) begin
                if (as | bs) begin
                    s  = sx(m_r[c], 48) + sx(p[c] & MASK, 48);
                    ov = (s > (MASK >> 1)) || (s < -(MASK >> 1) - 1);
                end else begin
                    s  = m_r[c] + (p[c] & MASK);
                    ov = s > MASK;
                end
                if (ov) m_ovf[c] = 1'b1;
                m_r[c] = s & MASK;
            end else begin
                m_r[c] = p[c] & MASK;
            end
        end
        m_have = 1; m_mode = md;
        sb_q.push_back('{48'(m_r[0]), 48'(m_r[1]), m_ovf});
    endtask

    // Monitor: every beat handed downstream is popped and compared.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got r0=%0h expected no output", result_0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_0", 64'(result_0), 64'(e.r0));
                chk("result_1", 64'(result_1), 64'(e.r1));
                chk("ovf", 64'(ovf), 64'(e.ovf));
            end
            obs_q.push_back('{result_0, result_1, ovf, cyc});
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(logic [53:0] av, logic [53:0] bv, bit as, bit bs, bit md, bit ac);
        bit ok = 0;
        a = av; b = bv; a_sign = as; b_sign = bs; mode = md; acc_en = ac; in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 within 1000 cycles");
        end else begin
            issue_cyc = cyc;
            model_push(av, bv, as, bs, md, ac);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(string nm);
        bit ok = 0;
        rnd_bp = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (sb_q.size() == 0 && !out_valid) begin ok = 1; break; end
            tick(1);
        end
        chk({nm, "_drained"}, 64'(ok), 64'd1);
    endtask

    initial begin
        int lat_issue;
        bit cur_md;
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result_0", 64'(result_0), 64'd0);
        chk("rst_result_1", 64'(result_1), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; reset_n = 1'b1;
        tick(1);

        // Signed full mode: -1 x 2, with latency
        obs_q.delete();
        issue(54'h7FFFFFF, 54'h00002, 1, 1, 0, 0);
        lat_issue = issue_cyc;
        drain("t_signed");
        chk("t_signed_count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() >= 1) begin
            chk("t_signed_r0", 64'(obs_q[0].r0), 64'hFFFFFFFFFFFE);
            chk("t_signed_r1", 64'(obs_q[0].r1), 64'd0);
            chk("t_signed_latency", 64'(obs_q[0].cyc - lat_issue), 64'd3);
        end

        // SIMD unsigned, all lanes 511
        obs_q.delete();
        issue({6{9'd511}}, {6{9'd511}}, 0, 0, 1, 0);
        drain("t_simd");
        if (obs_q.size() >= 1) begin
            chk("t_simd_r0", 64'(obs_q[0].r0), 64'd783363);
            chk("t_simd_r1", 64'(obs_q[0].r1), 64'd783363);
        end

        // Accumulation chain then restart on mode change
        obs_q.delete();
        for (int i = 0; i < 4; i++) issue(54'd1000, 54'd1000, 0, 0, 0, i != 0);
        issue({6{9'd2}}, {6{9'd2}}, 0, 0, 1, 1);
        drain("t_acc");
        chk("t_acc_count", 64'(obs_q.size()), 64'd5);
        if (obs_q.size() >= 5) begin
            for (int i = 0; i < 4; i++)
                chk("t_acc_r0", 64'(obs_q[i].r0), 64'(1000000 * (i + 1)));
            chk("t_acc_restart_r0", 64'(obs_q[4].r0), 64'd12);
            chk("t_acc_restart_r1", 64'(obs_q[4].r1), 64'd12);
        end

        // Backpressure: three beats held behind out_ready = 0
        obs_q.delete();
        out_ready = 1'b0;
        issue(54'd5, 54'd7, 0, 0, 0, 0);
        issue(54'd6, 54'd7, 0, 0, 0, 0);
        issue(54'd100, 54'd3, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_result_held", 64'(result_0), 64'd35);
        end
        @(posedge clk); #1;
        drain("t_bp");
        chk("t_bp_count", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() >= 3) begin
            chk("t_bp_r0_0", 64'(obs_q[0].r0), 64'd35);
            chk("t_bp_r0_1", 64'(obs_q[1].r0), 64'd42);
            chk("t_bp_r0_2", 64'(obs_q[2].r0), 64'd300);
            chk("t_bp_consec_1", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd1);
            chk("t_bp_consec_2", 64'(obs_q[2].cyc - obs_q[1].cyc), 64'd1);
        end

        // Unsigned overflow after nine accumulations, then clear
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; m_ovf = 2'b00;
        obs_q.delete();
        for (int i = 0; i < 9; i++) issue(54'h7FFFFFF, 54'h3FFFF, 0, 0, 0, i != 0);
        drain("t_ovf");
        if (obs_q.size() >= 9) begin
            chk("t_ovf_beat8", 64'(obs_q[7].ovf), 64'd0);
            chk("t_ovf_beat9", 64'(obs_q[8].ovf), 64'd1);
        end
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; m_ovf = 2'b00;
        @(negedge clk);
        chk("t_ovf_cleared", 64'(ovf), 64'd0);
        @(posedge clk); #1;

        // Reset with two beats in flight
        issue(54'd11, 54'd13, 0, 0, 0, 0);
        issue(54'd17, 54'd19, 0, 0, 0, 1);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result_0", 64'(result_0), 64'd0);
        chk("mid_rst_result_1", 64'(result_1), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        obs_q.delete();
        tick(8);
        chk("mid_rst_no_output", 64'(obs_q.size()), 64'd0);
        issue(54'd3, 54'd4, 0, 0, 0, 1);
        drain("t_post_rst");
        if (obs_q.size() >= 1)
            chk("t_post_rst_r0", 64'(obs_q[0].r0), 64'd12);

        // Randomized traffic with random backpressure
        rnd_bp = 1'b1;
        cur_md = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) cur_md = ~cur_md;
            issue(54'({$urandom(), $urandom()}), 54'({$urandom(), $urandom()}),
                  $urandom_range(0, 1), $urandom_range(0, 1), cur_md,
                  $urandom_range(0, 3) != 0);
        end
        drain("t_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
